// File: rtl/rv32i_pkg.sv
// Shared constants and helpers for the RV32I front end.
package rv32i_pkg;

    localparam int WIDTH       = 32;
    localparam int INSTR_BYTES = 4;
    localparam int FETCH_DEPTH = 4;

    typedef logic [WIDTH-1:0] word_t;

    localparam word_t RESET_ADDR = 32'h0000_0000;
    localparam word_t NOP        = 32'h0000_0013;

    // Force an address onto an instruction boundary by clearing the low bits.
    function automatic word_t word_align(input word_t addr);
        return addr & ~word_t'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction buffer. A slot is allocated (address only) when a
// request is granted, filled when its read data returns, and freed when the
// decode stage takes it. Allocation, fill and pop each walk their own
// pointer, so ordering is strictly FIFO. A flush frees every slot at once.
module fetch_buffer
    import rv32i_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int W     = WIDTH,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  logic          i_alloc,
    input  logic [W-1:0]  i_alloc_addr,
    input  logic          i_fill,
    input  logic [W-1:0]  i_fill_data,
    input  logic          i_pop,
    output logic          o_head_valid,
    output logic [W-1:0]  o_head_data,
    output logic [W-1:0]  o_head_addr,
    output logic [CW-1:0] o_occupancy,
    output logic [CW-1:0] o_unfilled,
    output logic          o_full
);

    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  r_addr   [DEPTH];
    logic [W-1:0]  r_data   [DEPTH];
    logic          r_filled [DEPTH];
    logic [PW-1:0] r_alloc_ptr;
    logic [PW-1:0] r_fill_ptr;
    logic [PW-1:0] r_head_ptr;
    logic [CW-1:0] r_occ;
    logic [CW-1:0] r_unfilled;

    logic w_alloc;
    logic w_fill;
    logic w_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // Guard every operation so a misbehaving neighbour cannot corrupt counts.
    always_comb begin
        w_alloc = i_alloc && !o_full && !i_flush;
        w_fill  = i_fill && (r_unfilled != '0) && !i_flush;
        w_pop   = i_pop && o_head_valid && !i_flush;
    end

    assign o_full       = (r_occ == FULL_CNT);
    assign o_occupancy  = r_occ;
    assign o_unfilled   = r_unfilled;
    assign o_head_valid = r_filled[r_head_ptr];
    assign o_head_data  = r_data[r_head_ptr];
    assign o_head_addr  = r_addr[r_head_ptr];

    // Slot payload: address written at allocation, instruction at fill.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr[r_alloc_ptr] <= i_alloc_addr;
        end
        if (w_fill) begin
            r_data[r_fill_ptr] <= i_fill_data;
        end
    end

    // Pointer, filled-flag and counter bookkeeping; reset and flush empty it.
    always_ff @(posedge clk) begin
        if (i_rst || i_flush) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_occ       <= '0;
            r_unfilled  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_filled[k] <= 1'b0;
            end
        end else begin
            // The three pointers always address different slots when active:
            // alloc hits a free slot, fill an allocated one, pop a filled one.
            if (w_alloc) begin
                r_alloc_ptr           <= next_idx(r_alloc_ptr);
                r_filled[r_alloc_ptr] <= 1'b0;
            end
            if (w_fill) begin
                r_fill_ptr           <= next_idx(r_fill_ptr);
                r_filled[r_fill_ptr] <= 1'b1;
            end
            if (w_pop) begin
                r_head_ptr           <= next_idx(r_head_ptr);
                r_filled[r_head_ptr] <= 1'b0;
            end

            case ({w_alloc, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase

            case ({w_alloc, w_fill})
                2'b10:   r_unfilled <= r_unfilled + 1'b1;
                2'b01:   r_unfilled <= r_unfilled - 1'b1;
                default: r_unfilled <= r_unfilled;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues word-aligned reads to instruction
// memory, buffers returned words in order and presents them to decode.
//
// Handshakes: imem_req/imem_gnt transfer a request in any cycle where both are
// high; imem_rvalid returns one word per accepted request, in order, at least
// one cycle later; inst_valid/inst_ready transfer the head instruction in any
// cycle where both are high. inst/inst_pc stay stable while inst_valid is high
// and inst_ready is low.
//
// After a redirect the buffer is emptied immediately, but memory still owes
// responses for requests that were granted earlier. Those are counted in a
// drop counter and discarded as they arrive, so they never reach a slot.
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_addr,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             inst_valid,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    input  logic             inst_ready
);

    logic [WIDTH-1:0] r_pc;
    logic [CW-1:0]    r_drop;
    logic [WIDTH-1:0] r_last_inst;
    logic [WIDTH-1:0] r_last_pc;

    logic             w_req;
    logic             w_grant;
    logic             w_fill;
    logic             w_pop;
    logic             w_full;
    logic             w_head_valid;
    logic [WIDTH-1:0] w_head_data;
    logic [WIDTH-1:0] w_head_addr;
    logic [CW-1:0]    w_occupancy;
    logic [CW-1:0]    w_unfilled;
    logic             w_rvalid_owed;
    logic [CW-1:0]    w_drop_load;

    // Request whenever a slot is free; occupancy is the registered count, so a
    // pop only frees room for the following cycle.
    always_comb begin
        w_req   = !rst && !redirect && !w_full;
        w_grant = w_req && imem_gnt;
        // A response is kept only if nothing is waiting to be dropped and no
        // redirect is discarding it this cycle.
        w_fill  = imem_rvalid && !redirect && (r_drop == '0);
        w_pop   = w_head_valid && inst_ready;
    end

    assign imem_req   = w_req;
    assign imem_addr  = r_pc;
    assign inst_valid = w_head_valid;
    assign inst       = w_head_valid ? w_head_data : r_last_inst;
    assign inst_pc    = w_head_valid ? w_head_addr : r_last_pc;

    // Outstanding responses are those still owed to the drop counter plus the
    // unfilled slots; a response arriving in the redirect cycle is one of them.
    always_comb begin
        w_rvalid_owed = imem_rvalid && ((r_drop != '0) || (w_unfilled != '0));
        w_drop_load   = r_drop + w_unfilled - CW'(w_rvalid_owed);
    end

    fetch_buffer #(
        .DEPTH (DEPTH),
        .W     (WIDTH)
    ) u_fetch_buffer (
        .clk          (clk),
        .i_rst        (rst),
        .i_flush      (redirect),
        .i_alloc      (w_grant),
        .i_alloc_addr (r_pc),
        .i_fill       (w_fill),
        .i_fill_data  (imem_rdata),
        .i_pop        (w_pop),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head_data),
        .o_head_addr  (w_head_addr),
        .o_occupancy  (w_occupancy),
        .o_unfilled   (w_unfilled),
        .o_full       (w_full)
    );

    // Fetch PC: a redirect wins over the increment; 32-bit addition wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_ADDR;
        end else if (redirect) begin
            r_pc <= word_align(redirect_addr);
        end else if (w_grant) begin
            r_pc <= r_pc + WIDTH'(INSTR_BYTES);
        end
    end

    // Drop counter: loaded on redirect, counted down by each stale response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= '0;
        end else if (redirect) begin
            r_drop <= w_drop_load;
        end else if (imem_rvalid && (r_drop != '0)) begin
            r_drop <= r_drop - 1'b1;
        end
    end

    // Remember the last presented instruction so outputs hold while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_inst <= '0;
            r_last_pc   <= '0;
        end else if (w_head_valid) begin
            r_last_inst <= w_head_data;
            r_last_pc   <= w_head_addr;
        end
    end

    // Occupancy is exported by the buffer for observation; fetch uses only
    // the full flag derived from it.
    logic w_unused_occ;
    assign w_unused_occ = ^w_occupancy;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch. A transaction-level model keeps the list
// of fetched-but-not-consumed instructions and the list of requests memory
// still owes, and predicts every output each cycle.
module tb_instr_fetch;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    instr_fetch #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counters
    int n_total = 0;
    int n_bad   = 0;
    int unsigned cyc = 0;

    // Model state: buffer contents (address + has-data flag), memory backlog.
    logic [31:0] q_addr[$];
    bit          q_fill[$];
    logic [31:0] mem_addr[$];
    int unsigned mem_due[$];
    bit          mem_live[$];
    int unsigned last_due;
    logic [31:0] m_pc;
    logic [31:0] m_last_inst;
    logic [31:0] m_last_pc;

    // Stimulus knobs
    int          gnt_pct, rdy_pct, redir_pct, rst_permil, lat_lo, lat_hi;
    bit          f_redir;
    logic [31:0] f_redir_addr;
    bit          f_rst;
    int          grants_seen;
    bit          obs_valid;
    logic [31:0] obs_pc;

    // Memory content: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ {a[7:0], 24'h000013};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q_addr.delete();
        q_fill.delete();
        mem_addr.delete();
        mem_due.delete();
        mem_live.delete();
        last_due    = 0;
        m_pc        = 32'h0000_0000;
        m_last_inst = 32'h0;
        m_last_pc   = 32'h0;
    endtask

    // One clock cycle: drive at negedge, check, advance the model, wait posedge.
    task automatic step();
        bit          e_req, e_valid;
        logic [31:0] e_inst, e_pc;
        int unsigned due;
        @(negedge clk);
        rst = f_rst || ($urandom_range(0, 999) < rst_permil);
        redirect = 1'b0;
        if (!rst) redirect = f_redir || ($urandom_range(0, 99) < redir_pct);
        redirect_addr = f_redir ? f_redir_addr : $urandom();
        imem_rvalid = !rst && (mem_addr.size() > 0) && (mem_due[0] <= cyc);
        imem_rdata  = imem_rvalid ? mem_word(mem_addr[0]) : $urandom();
        imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
        inst_ready  = ($urandom_range(0, 99) < rdy_pct);
        f_redir = 1'b0;
        f_rst   = 1'b0;
        #1;
        e_req   = !rst && !redirect && (q_addr.size() < DEPTH);
        e_valid = (q_addr.size() > 0) && q_fill[0];
        e_inst  = e_valid ? mem_word(q_addr[0]) : m_last_inst;
        e_pc    = e_valid ? q_addr[0] : m_last_pc;
        check_eq("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
        check_eq("inst", inst, e_inst);
        check_eq("inst_pc", inst_pc, e_pc);
        obs_valid = inst_valid;
        obs_pc    = inst_pc;
        if (imem_req && imem_gnt) grants_seen++;

        // Advance the model with what happens at this edge.
        if (e_valid) begin
            m_last_inst = e_inst;
            m_last_pc   = e_pc;
        end
        if (e_valid && inst_ready) begin
            void'(q_addr.pop_front());
            void'(q_fill.pop_front());
        end
        if (imem_rvalid) begin
            if (mem_live[0]) begin
                for (int i = 0; i < q_fill.size(); i++) begin
                    if (!q_fill[i]) begin
                        q_fill[i] = 1'b1;
                        break;
                    end
                end
            end
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
            void'(mem_live.pop_front());
        end
        if (e_req && imem_gnt) begin
            due = cyc + $urandom_range(lat_lo, lat_hi);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_addr.push_back(m_pc);
            mem_due.push_back(due);
            mem_live.push_back(1'b1);
            q_addr.push_back(m_pc);
            q_fill.push_back(1'b0);
            m_pc = m_pc + 32'd4;
        end
        if (redirect) begin
            q_addr.delete();
            q_fill.delete();
            foreach (mem_live[i]) mem_live[i] = 1'b0;
            m_pc = redirect_addr & 32'hFFFF_FFFC;
        end
        if (rst) model_reset();
        @(posedge clk);
        cyc++;
    endtask

    task automatic set_knobs(input int g, input int r, input int rd, input int rs, input int lo, input int hi);
        gnt_pct = g; rdy_pct = r; redir_pct = rd; rst_permil = rs; lat_lo = lo; lat_hi = hi;
    endtask

    task automatic do_reset();
        f_rst = 1'b1;
        step();
        grants_seen = 0;
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first;
        bit          found;
        logic [31:0] pc_seen;

        rst = 1'b1; redirect = 1'b0; redirect_addr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        f_redir = 1'b0; f_redir_addr = '0; f_rst = 1'b0; grants_seen = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_req", {31'b0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'b0, inst_valid}, 32'd0);
        check_eq("rst_inst", inst, 32'd0);
        check_eq("rst_pc", inst_pc, 32'd0);
        check_eq("rst_addr", imem_addr, 32'd0);

        // Streaming with a one-cycle memory: first valid two cycles after reset.
        set_knobs(100, 100, 0, 0, 1, 1);
        first = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (first < 0 && obs_valid) first = i;
        end
        check_eq("first_valid_lat", first, 32'd2);

        // Decode stalled: exactly DEPTH grants, then release.
        do_reset();
        set_knobs(100, 0, 0, 0, 1, 1);
        repeat (10) step();
        check_eq("stall_grants", grants_seen, DEPTH);
        set_knobs(100, 100, 0, 0, 1, 1);
        repeat (12) step();

        // Redirect with two requests in flight, unaligned target.
        do_reset();
        set_knobs(100, 100, 0, 0, 3, 3);
        repeat (2) step();
        f_redir = 1'b1; f_redir_addr = 32'h0000_0103;
        step();
        found = 1'b0; pc_seen = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (obs_valid) begin found = 1'b1; pc_seen = obs_pc; end
        end
        check_eq("redir_first_pc", pc_seen, 32'h0000_0100);

        // Redirect while a response returns and decode takes the head.
        do_reset();
        set_knobs(100, 100, 0, 0, 2, 2);
        repeat (8) step();
        f_redir = 1'b1; f_redir_addr = 32'h0000_0200;
        step();
        repeat (10) step();

        // Fetch PC wrap at the top of the address space.
        f_redir = 1'b1; f_redir_addr = 32'hFFFF_FFF8;
        step();
        repeat (10) step();

        // Reset with the buffer partly full.
        set_knobs(100, 0, 0, 0, 1, 1);
        repeat (2) step();
        do_reset();
        set_knobs(100, 100, 0, 0, 1, 1);
        repeat (8) step();

        // Random traffic, including back-to-back redirects and resets.
        set_knobs(70, 70, 6, 5, 1, 3);
        repeat (1500) step();
        set_knobs(90, 40, 30, 0, 1, 3);
        repeat (300) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 WIDTH, 32, address/instruction width.
REQ-002 RESET_ADDR, 32'h0000_0000, fetch address after reset.
REQ-003 DEPTH, 4, instruction buffer slots; legal range 2..8.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 redirect  input  1  branch/jump taken; replaces fetch address and flushes buffer.
REQ-007 redirect_addr  input  WIDTH  new fetch address; bits [1:0] ignored, treated as 00.
REQ-008 imem_req  output  1  instruction memory request valid.
REQ-009 imem_addr  output  WIDTH  request address, word aligned.
REQ-010 imem_gnt  input  1  request accepted in the cycle imem_req && imem_gnt.
REQ-011 imem_rvalid  input  1  read data valid; exactly one per accepted request, in order, at least 1 cycle after grant.
REQ-012 imem_rdata  input  WIDTH  instruction word.
REQ-013 inst_valid  output  1  buffer head holds a returned instruction.
REQ-014 inst  output  WIDTH  head instruction.
REQ-015 inst_pc  output  WIDTH  address of head instruction.
REQ-016 inst_ready  input  1  decode accepts head; handshake when inst_valid && inst_ready.

Function
REQ-017 Internal fetch PC drives imem_addr; it SHALL advance by 4 on each accepted request, wrapping modulo 2^32.
REQ-018 Buffer slot allocated at grant, storing the address; slot filled at imem_rvalid; slot freed on decode handshake; order strictly FIFO.
REQ-019 imem_req SHALL assert iff occupancy (allocated slots, counted at cycle start, no same-cycle bypass) < DEPTH, redirect low, rst low.
REQ-020 inst_valid SHALL assert the cycle after the head slot is filled; inst/inst_pc SHALL be stable while inst_valid && !inst_ready.
REQ-021 Latency: grant in cycle N, rvalid in N+1 -> inst_valid in N+2; with 1-cycle memory, continuous grant and ready, DEPTH>=3 SHALL sustain one instruction per cycle.
REQ-022 Full: occupancy == DEPTH -> imem_req low; it re-asserts the cycle after a pop.
REQ-023 Empty: inst_valid low; inst and inst_pc hold their last values.
REQ-024 Redirect: in that cycle, imem_req low and all slots freed; next cycle fetch PC = redirect_addr & ~3 and requesting resumes.
REQ-025 Responses to requests granted before a redirect SHALL be dropped via a drop counter (width clog2(DEPTH+1)) loaded with the count of unfilled slots; each such rvalid decrements it and writes nothing.
REQ-026 A redirect coinciding with an rvalid SHALL drop that response and load the counter with the remaining unfilled count.
REQ-027 A decode handshake in a redirect cycle counts as consumed; the flush still applies.
REQ-028 Back-to-back redirects: the last redirect wins; the drop counter accumulates correctly.

Reset
REQ-029 When rst is high at a clock edge: fetch PC = RESET_ADDR, slots cleared, drop counter = 0, imem_req = 0, inst_valid = 0, inst = 0, inst_pc = 0.
REQ-030 Reset mid-operation SHALL discard all in-flight state; the memory SHALL be reset by the same rst, with no stale rvalid after it.
REQ-031 First request SHALL be issued in the first cycle with rst low.

Structure
REQ-032 Package rv32i_pkg SHALL hold WIDTH, RESET_ADDR, INSTR_BYTES = 4 and NOP = 32'h0000_0013.
REQ-033 One sub-module, fetch_buffer: circular slot array with alloc/fill/pop pointers, per-slot filled flag and occupancy count.

Verification
REQ-034 Reset, then 1-cycle memory, gnt=1, ready=1 -> inst_pc 0,4,8,12 on consecutive cycles; first inst_valid 2 cycles after rst falls.
REQ-035 inst_ready=0 for 10 cycles -> exactly DEPTH=4 grants, then imem_req low; release ready -> addresses 0..12 delivered in order, and requests resume at 16.
REQ-036 Redirect to 32'h100 with 2 requests outstanding -> both responses dropped; next inst_pc = 32'h100; redirect_addr 32'h103 -> fetch at 32'h100.
REQ-037 Redirect in the same cycle as an rvalid and a decode handshake -> no stale instruction delivered; drop count is correct.
REQ-038 Fetch PC at 32'hFFFF_FFFC -> next request address 32'h0000_0000.
REQ-039 rst asserted mid-stream with the buffer half full -> next cycle inst_valid=0 and imem_req=0; after release, fetch restarts at RESET_ADDR.
